// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and a saturating bubble counter.
// One cycle push-to-output latency; define PIPE_STAGE_REG_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int                 INSTR_W   = 16,
  parameter int                 PAYLOAD_W = 84,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t               state;
  state_t               state_nxt;
  logic                 push;
  logic                 pop;
  logic [INSTR_W-1:0]   main_instr;
  logic [PAYLOAD_W-1:0] main_payload;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic                 rdy_q;
  logic [INSTR_W-1:0]   skid_instr;
  logic [PAYLOAD_W-1:0] skid_payload;
`endif

  // in_ready already folds in !flush, so a push never coincides with a flush.
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_instr   = main_instr;
  assign out_payload = main_payload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) state_nxt = ONE;
`ifdef PIPE_STAGE_REG_SKID_EN
        ONE: begin
          if (push && !pop)      state_nxt = TWO;
          else if (pop && !push) state_nxt = EMPTY;
        end
        TWO: if (pop) state_nxt = ONE;
`else
        ONE: if (pop && !push) state_nxt = EMPTY;
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state != EMPTY);
`ifdef PIPE_STAGE_REG_SKID_EN
    in_ready  = rdy_q && !flush;
`else
    in_ready  = (!out_valid || out_ready) && !flush;
`endif
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  // Registered ready: deasserts only once both entries are occupied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= (state_nxt != TWO);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_instr   <= NOP_INSTR;
      main_payload <= '0;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_instr   <= NOP_INSTR;
      skid_payload <= '0;
`endif
    end else if (flush) begin
      main_instr <= NOP_INSTR;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_instr   <= in_instr;
            main_payload <= in_payload;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_instr   <= in_instr;
            main_payload <= in_payload;
`ifdef PIPE_STAGE_REG_SKID_EN
          end else if (push) begin
            skid_instr   <= in_instr;
            skid_payload <= in_payload;
`endif
          end else if (pop) begin
            main_instr <= NOP_INSTR;
          end
        end
`ifdef PIPE_STAGE_REG_SKID_EN
        TWO: begin
          if (pop) begin
            main_instr   <= skid_instr;
            main_payload <= skid_payload;
          end
        end
`endif
        default: main_instr <= NOP_INSTR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (!out_valid && bubble_cnt != CNT_MAX) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [83:0] in_payload = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [83:0] out_payload;
  logic        cnt_clr = 1'b0;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  pipe_stage_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_payload(out_payload),
    .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [83:0] payload;
  } entry_t;

  entry_t       q[$];
  logic [83:0]  m_pay = '0;
  int           m_cnt = 0;

  function automatic logic [83:0] pay(input logic [15:0] i);
    return {{5{i}}, 4'h9};
  endfunction

  // Stage capacity is two entries with the skid buffer, one without.
  function automatic logic exp_rdy();
`ifdef PIPE_STAGE_REG_SKID_EN
    return (q.size() < 2) && !flush;
`else
    return (q.size() == 0 || out_ready) && !flush;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    int sz;
    logic rdy;
    if (!rst) begin
      q.delete();
      m_pay = '0;
      m_cnt = 0;
    end else begin
      sz  = q.size();
      rdy = exp_rdy();
      if (cnt_clr) m_cnt = 0;
      else if (sz == 0 && m_cnt < (1 << CW) - 1) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (sz > 0 && out_ready) void'(q.pop_front());
        if (in_valid && rdy) q.push_back('{instr: in_instr, payload: in_payload});
      end
      if (q.size() > 0) m_pay = q[0].payload;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 128'(out_valid), 128'(q.size() > 0));
      check("out_instr", 128'(out_instr), 128'(q.size() > 0 ? q[0].instr : 16'h0000));
      check("out_payload", 128'(out_payload), 128'(m_pay));
      check("in_ready", 128'(in_ready), 128'(exp_rdy()));
      check("bubble_cnt", 128'(bubble_cnt), 128'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] i);
    in_valid   = v;
    in_instr   = i;
    in_payload = pay(i);
  endtask

  initial begin
    #1 rst = 1'b0;
    started = 1'b1;
    // Reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'($urandom);
      flush     = 1'($urandom);
      out_ready = 1'($urandom);
      cnt_clr   = 1'($urandom);
      in_instr  = 16'($urandom);
      in_payload = pay(in_instr);
      tick();
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_out_instr", 128'(out_instr), 128'h0);
      check("rst_out_payload", 128'(out_payload), 128'h0);
      check("rst_bubble", 128'(bubble_cnt), 128'd0);
      check("rst_in_ready", 128'(in_ready), 128'(!flush));
    end
    flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    drive(1'b1, 16'h1234);
    rst = 1'b1;
    tick();
    check("first_push_valid", 128'(out_valid), 128'd1);
    check("first_push_instr", 128'(out_instr), 128'h1234);

    // Streaming
    drive(1'b0, 16'h0); out_ready = 1'b1;
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 16'(i));
      tick();
      check("stream_instr", 128'(out_instr), 128'(i));
      check("stream_valid", 128'(out_valid), 128'd1);
    end
    check("stream_bubble_frozen", 128'(bubble_cnt), 128'd1);
    drive(1'b0, 16'h0);
    tick();
    check("stream_drained", 128'(out_valid), 128'd0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 16'hA000);
    tick();
    drive(1'b1, 16'hA001);
    tick();
    drive(1'b0, 16'h0);
    #1;
    check("bp_in_ready", 128'(in_ready), 128'd0);
    check("bp_hold_instr", 128'(out_instr), 128'hA000);
    tick();
    check("bp_hold_instr2", 128'(out_instr), 128'hA000);
    out_ready = 1'b1;
`ifndef PIPE_STAGE_REG_SKID_EN
    #1;
    check("bp_ready_tracks", 128'(in_ready), 128'd1);
`endif
    tick();
`ifdef PIPE_STAGE_REG_SKID_EN
    check("bp_second_pop", 128'(out_instr), 128'hA001);
    check("bp_ready_back", 128'(in_ready), 128'd1);
    tick();
`endif
    check("bp_empty", 128'(out_valid), 128'd0);

    // Flush while full
    out_ready = 1'b0;
    drive(1'b1, 16'hC000);
    tick();
    drive(1'b1, 16'hC001);
    tick();
    drive(1'b1, 16'hD000);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 128'(in_ready), 128'd0);
    tick();
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 16'h0);
    check("flush_valid", 128'(out_valid), 128'd0);
    check("flush_nop", 128'(out_instr), 128'h0);
    check("flush_payload_held", 128'(out_payload), 128'(pay(16'hC000)));
    tick();
    check("flush_no_accept", 128'(out_valid), 128'd0);

    // Bubble counter
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_cleared", 128'(bubble_cnt), 128'd0);
    repeat (10) tick();
    check("cnt_10", 128'(bubble_cnt), 128'd10);
    repeat (10) tick();
    check("cnt_sat", 128'(bubble_cnt), 128'd15);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_clr_wins", 128'(bubble_cnt), 128'd0);

    // Reset in the middle of a transfer
    out_ready = 1'b0;
    drive(1'b1, 16'hE000);
    tick();
    drive(1'b0, 16'h0);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", 128'(out_valid), 128'd0);
    check("midrst_instr", 128'(out_instr), 128'h0);
    check("midrst_payload", 128'(out_payload), 128'h0);
    tick();
    drive(1'b1, 16'hF000);
    rst = 1'b1;
    tick();
    check("post_rst_push", 128'(out_instr), 128'hF000);

    // Randomised traffic against the model
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom), 16'($urandom));
      out_ready = 1'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      tick();
    end
    drive(1'b0, 16'h0);
    flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
